// File: rtl/tick_scheduler_pkg.sv
// Shared constants for the tick scheduler: channel count, prescaler width,
// arbiter pointer width and the default prescaler divisor (20 MHz -> 1 Hz).
package tick_sched_pkg;

  localparam int NCH     = 4;
  localparam int PTR_W   = 2;
  localparam int PRESC_W = 25;

  localparam logic [PRESC_W-1:0] DIVISOR_DEFAULT = 25'd20000000;

endpackage

// File: rtl/tick_scheduler_rr_arbiter4.sv
// Four-way round-robin arbiter. Picks the first eligible channel found
// when scanning upward (with wrap) from the pointer; output is one-hot or zero.
module rr_arbiter4
  import tick_sched_pkg::*;
(
  input  logic [3:0] elig,
  input  logic [1:0] ptr,
  output logic [3:0] grant
);

  // Scan from the pointer and take the first eligible channel
  always_comb begin
    logic             found;
    logic [PTR_W-1:0] idx;
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = ptr + PTR_W'(k);
      if (!found && elig[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// Four-channel tick scheduler: a shared prescaler produces one tick every
// DIVISOR cycles while any channel is armed; each channel counts down its
// requested number of ticks and pulses done on expiry.
// Optional feature: define TICK_SCHEDULER_CANCEL_EN to add a per-channel
// cancel input that aborts a busy channel without a done pulse.
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter logic [PRESC_W-1:0] DIVISOR = DIVISOR_DEFAULT,
  parameter int                 LEN_W   = 8
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic [3:0]       req,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  input  logic [LEN_W-1:0] len2,
  input  logic [LEN_W-1:0] len3,
`ifdef TICK_SCHEDULER_CANCEL_EN
  input  logic [3:0]       cancel,
`endif
  output logic [3:0]       grant,
  output logic [3:0]       busy,
  output logic [3:0]       done,
  output logic             tick
);

  localparam logic [PRESC_W-1:0] PRESC_MAX = DIVISOR - 25'd1;

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               run_q, run_d;
  logic [NCH-1:0]     busy_q, busy_d;
  logic [LEN_W-1:0]   rem_q [NCH];
  logic [LEN_W-1:0]   rem_d [NCH];

  logic [LEN_W-1:0]   len_arr [NCH];
  logic [NCH-1:0]     elig;
  logic [NCH-1:0]     grant_w;
  logic [NCH-1:0]     done_w;
  logic [NCH-1:0]     cancel_w;
  logic               tick_w;

  assign len_arr[0] = len0;
  assign len_arr[1] = len1;
  assign len_arr[2] = len2;
  assign len_arr[3] = len3;

`ifdef TICK_SCHEDULER_CANCEL_EN
  assign cancel_w = cancel & busy_q;
`else
  assign cancel_w = '0;
`endif

  // Tick, expiry pulses and eligibility; run_q keeps grants off until the
  // first clock edge after reset release
  always_comb begin
    tick_w = run_q && (presc_q == PRESC_MAX);
    done_w = '0;
    for (int i = 0; i < NCH; i++) begin
      done_w[i] = tick_w && busy_q[i] && (rem_q[i] == LEN_W'(1)) && !cancel_w[i];
    end
    elig = run_q ? (req & ~busy_q & ~done_w) : '0;
  end

  rr_arbiter4 u_arb (
    .elig  (elig),
    .ptr   (ptr_q),
    .grant (grant_w)
  );

  // Next-state for prescaler, arbiter pointer and per-channel counters
  always_comb begin
    presc_d = presc_q;
    ptr_d   = ptr_q;
    run_d   = 1'b1;
    busy_d  = busy_q;
    for (int i = 0; i < NCH; i++) begin
      rem_d[i] = rem_q[i];
    end

    // Idle prescaler parks at 0 so a grant from idle sees a full period
    if (busy_q == '0) begin
      presc_d = '0;
    end else if (presc_q == PRESC_MAX) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PRESC_W'(1);
    end

    for (int i = 0; i < NCH; i++) begin
      if (cancel_w[i]) begin
        busy_d[i] = 1'b0;
        rem_d[i]  = '0;
      end else if (busy_q[i] && tick_w) begin
        rem_d[i] = rem_q[i] - LEN_W'(1);
        if (rem_q[i] == LEN_W'(1)) begin
          busy_d[i] = 1'b0;
        end
      end
      // A granted channel is never busy, so loading cannot collide with
      // the decrement above; a same-cycle tick therefore does not count
      if (grant_w[i]) begin
        rem_d[i]  = (len_arr[i] == '0) ? LEN_W'(1) : len_arr[i];
        busy_d[i] = 1'b1;
        ptr_d     = PTR_W'(i + 1);
      end
    end
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      ptr_q   <= '0;
      run_q   <= 1'b0;
      busy_q  <= '0;
      for (int i = 0; i < NCH; i++) begin
        rem_q[i] <= '0;
      end
    end else begin
      presc_q <= presc_d;
      ptr_q   <= ptr_d;
      run_q   <= run_d;
      busy_q  <= busy_d;
      for (int i = 0; i < NCH; i++) begin
        rem_q[i] <= rem_d[i];
      end
    end
  end

  assign grant = grant_w;
  assign busy  = busy_q;
  assign done  = done_w;
  assign tick  = tick_w;

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler with DIVISOR=4, LEN_W=8. A timeline model predicts
// grant/busy/done/tick every cycle; directed scenarios add literal checks.
module tb_tick_scheduler;

  localparam int D = 4;

  logic       clock_in = 1'b0;
  logic       reset_n  = 1'b0;
  logic [3:0] req      = '0;
  logic [7:0] len0 = '0, len1 = '0, len2 = '0, len3 = '0;
  logic [3:0] grant, busy, done;
  logic       tick;
`ifdef TICK_SCHEDULER_CANCEL_EN
  logic [3:0] cancel = '0;
`endif

  tick_scheduler #(.DIVISOR(25'd4), .LEN_W(8)) dut (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .req      (req),
    .len0     (len0),
    .len1     (len1),
    .len2     (len2),
    .len3     (len3),
`ifdef TICK_SCHEDULER_CANCEL_EN
    .cancel   (cancel),
`endif
    .grant    (grant),
    .busy     (busy),
    .done     (done),
    .tick     (tick)
  );

  always #5 clock_in = ~clock_in;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic void chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- timeline model ----------------
  // Each armed channel is described by its grant cycle and the cycle its
  // done pulse is due; ticks are tracked as the cycle of the next tick.
  int cyc = 0;
  bit m_run = 0;
  bit armed [4];
  int g_cyc [4];
  int d_cyc [4];
  int next_tick = -1;
  int m_ptr = 0;

  always @(negedge clock_in) begin : compare
    logic [3:0] eb, ed, el, eg;
    logic       et;
    int         lens [4];
    int         gi, j, L, first;
    cyc++;
    if (!reset_n) begin
      chk("rst_grant", grant, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_tick", tick, 0);
      for (int i = 0; i < 4; i++) armed[i] = 0;
      next_tick = -1;
      m_ptr = 0;
      m_run = 0;
    end else begin
      lens[0] = len0; lens[1] = len1; lens[2] = len2; lens[3] = len3;
      eb = '0;
      ed = '0;
      for (int i = 0; i < 4; i++) begin
        if (armed[i] && cyc > g_cyc[i] && cyc <= d_cyc[i]) eb[i] = 1'b1;
        if (armed[i] && cyc == d_cyc[i]) ed[i] = 1'b1;
      end
      et = m_run && (next_tick == cyc);
      el = m_run ? (req & ~eb & ~ed) : 4'b0;
      eg = '0;
      gi = -1;
      for (int k = 0; k < 4; k++) begin
        j = (m_ptr + k) % 4;
        if (gi < 0 && el[j]) begin
          gi = j;
          eg[j] = 1'b1;
        end
      end
      chk("model_grant", grant, eg);
      chk("model_busy", busy, eb);
      chk("model_done", done, ed);
      chk("model_tick", tick, et);
      if (gi >= 0) begin
        L = (lens[gi] == 0) ? 1 : lens[gi];
        first = (eb == 0 || next_tick == cyc) ? cyc + D : next_tick;
        d_cyc[gi] = first + (L - 1) * D;
        g_cyc[gi] = cyc;
        armed[gi] = 1;
        m_ptr = (gi + 1) % 4;
      end
      if (eb == 0) next_tick = (gi >= 0) ? cyc + D : -1;
      else if (next_tick == cyc) next_tick = next_tick + D;
      m_run = 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  task automatic wait_grant(input logic [3:0] g);
    bit ok;
    ok = 0;
    for (int n = 0; n < 30 && !ok; n++) begin
      @(negedge clock_in);
      if (grant == g) ok = 1;
    end
    if (!ok) chk("grant_timeout", grant, g);
  endtask

  initial begin
    // Directed 1: single channel, len=3, from idle
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    len0 = 8'd3;
    req  = 4'b0001;
    wait_grant(4'b0001);
    for (int k = 1; k <= 13; k++) begin
      step();
      if (k == 1) req = 4'b0000;
      @(negedge clock_in);
      if (k == 1)  chk("d1_busy_T1", busy, 4'b0001);
      if (k == 3)  chk("d1_notick_T3", tick, 0);
      if (k == 4)  chk("d1_tick_T4", tick, 1);
      if (k == 8)  chk("d1_tick_T8", tick, 1);
      if (k == 11) chk("d1_busy_T11", busy, 4'b0001);
      if (k == 12) chk("d1_done_T12", done, 4'b0001);
      if (k == 13) chk("d1_busy_T13", busy, 4'b0000);
    end

    // Directed 2: all four requesting from reset, len=2
    step();
    reset_n = 1'b0;
    req = 4'b1111;
    len0 = 8'd2; len1 = 8'd2; len2 = 8'd2; len3 = 8'd2;
    step();
    step();
    reset_n = 1'b1;
    wait_grant(4'b0001);
    for (int k = 1; k <= 9; k++) begin
      step();
      @(negedge clock_in);
      if (k == 1) chk("d2_grant1", grant, 4'b0010);
      if (k == 2) chk("d2_grant2", grant, 4'b0100);
      if (k == 3) chk("d2_grant3", grant, 4'b1000);
      if (k == 5) chk("d2_busy_all", busy, 4'b1111);
      if (k == 8) chk("d2_done_all", done, 4'b1111);
      if (k == 9) chk("d2_regrant0", grant, 4'b0001);
    end
    step();
    req = 4'b0000;
    repeat (12) step();

    // Directed 3: len1=0 granted on a tick while channel 0 is busy
    len0 = 8'd5;
    len1 = 8'd0;
    req  = 4'b0001;
    wait_grant(4'b0001);
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k == 1) req = 4'b0000;
      if (k == 4) req = 4'b0110;
      if (k == 5) req = 4'b0000;
      @(negedge clock_in);
      if (k == 4) chk("d3_grant_on_tick", grant, 4'b0010);
      if (k == 4) chk("d3_tick_T4", tick, 1);
      if (k == 5) chk("d3_busy_T5", busy, 4'b0011);
      if (k == 8) chk("d3_done1_T8", done, 4'b0010);
    end
    repeat (16) step();

    // Directed 4: reset mid-period while channel 0 has remaining=2
    len0 = 8'd3;
    req  = 4'b0001;
    wait_grant(4'b0001);
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 1) req = 4'b0000;
    end
    #1;
    reset_n = 1'b0;
    #1;
    chk("d4_async_busy", busy, 0);
    chk("d4_async_done", done, 0);
    chk("d4_async_grant", grant, 0);
    chk("d4_async_tick", tick, 0);
    step();
    step();
    reset_n = 1'b1;
    req = 4'b0001;
    wait_grant(4'b0001);
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 1) req = 4'b0000;
      @(negedge clock_in);
      if (k == 12) chk("d4_done_after_reset", done, 4'b0001);
    end
    repeat (3) step();

    // Directed 5: channels 1 and 3 from a non-zero pointer
    len1 = 8'd1;
    len3 = 8'd3;
    req  = 4'b1010;
    wait_grant(4'b0010);
    for (int k = 1; k <= 13; k++) begin
      step();
      if (k == 2) req = 4'b0000;
      @(negedge clock_in);
      if (k == 1)  chk("d5_grant3", grant, 4'b1000);
      if (k == 4)  chk("d5_done1", done, 4'b0010);
      if (k == 12) chk("d5_done3", done, 4'b1000);
      if (k == 13) chk("d5_idle", busy, 4'b0000);
    end
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
